// File: rtl/ppi_strobe_peer.sv
// Peripheral-side partner for an 8255 strobed port: ACKs PPI output bytes into an rx FIFO
// and strobes tx FIFO bytes into the PPI input latch, with a sticky wait-state timeout.

module ppi_strobe_fifo #(
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);
  logic [7:0]    mem [2**AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // level never exceeds 2^AW, so its top bit alone means full
  assign full    = level[AW];
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

module ppi_strobe_peer #(
  parameter int AW      = 2,
  parameter int ACK_W   = 2,
  parameter int SETUP   = 1,
  parameter int STB_W   = 2,
  parameter int HOLD    = 1,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [7:0]    pd_din,
  output logic [7:0]    pd_dout,
  output logic          pd_oe,
  input  logic          obf_n,
  output logic          ack_n,
  input  logic          ibf,
  output logic          stb_n,
  input  logic [7:0]    tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic [7:0]    rx_data,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic [AW:0]   tx_level,
  output logic [AW:0]   rx_level,
  output logic          busy,
  output logic          timeout_err,
  input  logic          clr_err
);
  typedef enum logic [2:0] {
    IDLE, RX_ACK, RX_WAIT, TX_SETUP, TX_STB, TX_HOLD, TX_WAIT
  } state_t;

  localparam logic [7:0] ACK_LAST   = 8'(ACK_W - 1);
  localparam logic [7:0] SETUP_LAST = 8'(SETUP - 1);
  localparam logic [7:0] STB_LAST   = 8'(STB_W - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD - 1);
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic       rx_push;
  logic       tx_pop;
  logic       to_hit;
  logic       rx_full;
  logic       rx_empty;
  logic       tx_full;
  logic       tx_empty;
  logic [7:0] tx_head;

  ppi_strobe_fifo #(.AW(AW)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .din   (pd_din),
    .pop   (rx_ready),
    .dout  (rx_data),
    .level (rx_level),
    .full  (rx_full),
    .empty (rx_empty)
  );

  ppi_strobe_fifo #(.AW(AW)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_valid),
    .din   (tx_data),
    .pop   (tx_pop),
    .dout  (tx_head),
    .level (tx_level),
    .full  (tx_full),
    .empty (tx_empty)
  );

  assign tx_ready = !tx_full;
  assign rx_valid = !rx_empty;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // One counter serves both pulse widths and the wait-state timeout; it restarts on every state change.
  always_ff @(posedge clk) begin
    if (rst)                    cnt <= '0;
    else if (state_nxt != state) cnt <= '0;
    else if (cnt != 8'hff)      cnt <= cnt + 8'd1;
  end

  always_comb begin
    state_nxt = state;
    rx_push   = 1'b0;
    tx_pop    = 1'b0;
    to_hit    = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          if (!obf_n && !rx_full) begin
            state_nxt = RX_ACK;
          end else if (!tx_empty && !ibf) begin
            tx_pop    = 1'b1;
            state_nxt = (SETUP == 0) ? TX_STB : TX_SETUP;
          end
        end
      end
      RX_ACK: begin
        if (cnt == ACK_LAST) begin
          rx_push   = 1'b1;
          state_nxt = RX_WAIT;
        end
      end
      RX_WAIT: begin
        if (obf_n) begin
          state_nxt = IDLE;
        end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
          to_hit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      TX_SETUP: begin
        if (cnt == SETUP_LAST) state_nxt = TX_STB;
      end
      TX_STB: begin
        if (cnt == STB_LAST) state_nxt = (HOLD == 0) ? TX_WAIT : TX_HOLD;
      end
      TX_HOLD: begin
        if (cnt == HOLD_LAST) state_nxt = TX_WAIT;
      end
      TX_WAIT: begin
        if (ibf) begin
          state_nxt = IDLE;
        end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
          to_hit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)         pd_dout <= '0;
    else if (tx_pop) pd_dout <= tx_head;
  end

  always_ff @(posedge clk) begin
    if (rst)          timeout_err <= 1'b0;
    else if (to_hit)  timeout_err <= 1'b1;
    else if (clr_err) timeout_err <= 1'b0;
  end

  assign ack_n = (state != RX_ACK);
  assign stb_n = (state != TX_STB);
  assign pd_oe = (state == TX_SETUP) || (state == TX_STB) || (state == TX_HOLD);
  assign busy  = (state != IDLE);
endmodule

// File: tb/tb_ppi_strobe_peer.sv
// Directed bench for ppi_strobe_peer: a PPI-side model drives the handshake pins, queues check data order.
module tb_ppi_strobe_peer;
  localparam int AW    = 2;
  localparam int ACK_W = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [7:0]    pd_din;
  logic [7:0]    pd_dout;
  logic          pd_oe;
  logic          obf_n;
  logic          ack_n;
  logic          ibf;
  logic          stb_n;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [AW:0]   tx_level;
  logic [AW:0]   rx_level;
  logic          busy;
  logic          timeout_err;
  logic          clr_err;

  int vectors = 0;
  int errors  = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  ppi_strobe_peer #(.AW(AW), .ACK_W(ACK_W), .SETUP(1), .STB_W(2), .HOLD(1), .TIMEOUT(10)) dut (
    .clk(clk), .rst(rst), .enable(enable), .pd_din(pd_din), .pd_dout(pd_dout), .pd_oe(pd_oe),
    .obf_n(obf_n), .ack_n(ack_n), .ibf(ibf), .stb_n(stb_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_level(tx_level), .rx_level(rx_level), .busy(busy), .timeout_err(timeout_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // PPI raises OBF (drives obf_n low) and waits for the ACK to begin
  task automatic ppi_offer(input logic [7:0] b, input int maxw, output int lat);
    pd_din = b;
    obf_n  = 1'b0;
    rx_q.push_back(b);
    lat = 0;
    while (ack_n !== 1'b0 && lat < maxw) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic ppi_finish();
    int w = 0;
    while (ack_n === 1'b0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("ack_width", w, ACK_W);
    obf_n  = 1'b1;
    pd_din = ~pd_din;
    @(negedge clk);
    chk("rx_idle", busy, 1'b0);
  endtask

  task automatic rx_pop();
    logic [7:0] e;
    e = 8'h00;
    if (rx_q.size() > 0) e = rx_q.pop_front();
    chk("rx_valid", rx_valid, 1'b1);
    chk("rx_data", rx_data, e);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic tx_push(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    if (tx_ready === 1'b1) tx_q.push_back(b);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic tx_observe();
    int n = 0;
    int s = 0;
    int t = 0;
    int h = 0;
    logic [7:0] e;
    e = 8'h00;
    if (tx_q.size() > 0) e = tx_q.pop_front();
    while (pd_oe !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("tx_start", pd_oe, 1'b1);
    while (pd_oe === 1'b1 && stb_n === 1'b1 && s < 20) begin
      chk("tx_setup_data", pd_dout, e);
      @(negedge clk);
      s++;
    end
    chk("tx_setup_cycles", s, 1);
    chk("tx_stb_data", pd_dout, e);
    while (stb_n === 1'b0 && t < 20) begin
      chk("tx_stb_oe", pd_oe, 1'b1);
      @(negedge clk);
      t++;
    end
    chk("tx_stb_cycles", t, 2);
    while (pd_oe === 1'b1 && stb_n === 1'b1 && h < 20) begin
      chk("tx_hold_data", pd_dout, e);
      @(negedge clk);
      h++;
    end
    chk("tx_hold_cycles", h, 1);
    chk("tx_wait_oe", pd_oe, 1'b0);
    chk("tx_wait_busy", busy, 1'b1);
  endtask

  task automatic tx_complete();
    ibf = 1'b1;
    @(negedge clk);
    chk("tx_done_busy", busy, 1'b0);
    ibf = 1'b0;
  endtask

  initial begin
    int lat;
    int c;
    rst = 1'b1; enable = 1'b1; pd_din = 8'h00; obf_n = 1'b1; ibf = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0; clr_err = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ack_n", ack_n, 1'b1);
    chk("rst_stb_n", stb_n, 1'b1);
    chk("rst_pd_oe", pd_oe, 1'b0);
    chk("rst_pd_dout", pd_dout, 8'h00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_tx_ready", tx_ready, 1'b1);
    chk("rst_tx_level", tx_level, 0);
    chk("rst_rx_level", rx_level, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", timeout_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // rx single byte
    ppi_offer(8'hA5, 10, lat);
    chk("rx_ack_latency", lat, 1);
    ppi_finish();
    chk("rx_level1", rx_level, 1);
    rx_pop();
    chk("rx_empty", rx_valid, 1'b0);

    // tx single byte
    tx_push(8'h3C);
    tx_observe();
    tx_complete();
    chk("tx_level0", tx_level, 0);

    // enable low blocks a new transfer
    enable = 1'b0;
    tx_push(8'hC3);
    repeat (5) @(negedge clk);
    chk("en_busy", busy, 1'b0);
    chk("en_level", tx_level, 1);
    enable = 1'b1;
    tx_observe();
    tx_complete();

    // tx FIFO fills while ibf holds the PPI latch; the fifth push is dropped
    ibf = 1'b1;
    for (int i = 0; i < 5; i++) tx_push(8'h40 + 8'(i));
    chk("tx_full_level", tx_level, 4);
    chk("tx_full_ready", tx_ready, 1'b0);
    ibf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tx_observe();
      tx_complete();
    end
    chk("tx_drained", tx_level, 0);

    // rx back-pressure: no ACK while the rx FIFO is full
    for (int i = 1; i <= 4; i++) begin
      ppi_offer(8'(i), 10, lat);
      ppi_finish();
    end
    chk("bp_level", rx_level, 4);
    ppi_offer(8'h05, 8, lat);
    chk("bp_noack", ack_n, 1'b1);
    chk("bp_level_held", rx_level, 4);
    rx_pop();
    lat = 0;
    while (ack_n !== 1'b0 && lat < 10) begin @(negedge clk); lat++; end
    chk("bp_fifth_ack", ack_n, 1'b0);
    ppi_finish();
    chk("bp_level_refill", rx_level, 4);
    for (int i = 0; i < 4; i++) rx_pop();

    // rx wins when both directions become pending together
    tx_data = 8'h77; tx_valid = 1'b1; tx_q.push_back(8'h77);
    @(negedge clk);
    tx_valid = 1'b0;
    ppi_offer(8'h5A, 4, lat);
    chk("prio_rx_first", lat, 1);
    chk("prio_no_tx", pd_oe, 1'b0);
    ppi_finish();
    tx_observe();
    tx_complete();
    rx_pop();

    // timeout in TX_WAIT
    tx_push(8'hE1);
    tx_observe();
    c = 0;
    while (timeout_err !== 1'b1 && c < 50) begin @(negedge clk); c++; end
    chk("to_cycles", c, 10);
    chk("to_idle", busy, 1'b0);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("to_clear", timeout_err, 1'b0);

    // reset in the middle of a strobe flushes both FIFOs
    ppi_offer(8'h11, 10, lat);
    ppi_finish();
    tx_push(8'h99);
    tx_push(8'h98);
    c = 0;
    while (stb_n !== 1'b0 && c < 20) begin @(negedge clk); c++; end
    chk("mid_stb_low", stb_n, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_stb_n", stb_n, 1'b1);
    chk("mid_rst_pd_oe", pd_oe, 1'b0);
    chk("mid_rst_tx_level", tx_level, 0);
    chk("mid_rst_rx_level", rx_level, 0);
    chk("mid_rst_busy", busy, 1'b0);
    rst = 1'b0;
    rx_q.delete();
    tx_q.delete();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
